// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetch between the fetch stage and a
//   variable-latency instruction memory. Keeps up to MAX_OUT requests in flight
//   and buffers returned words with their PCs in a DEPTH-entry FIFO.
// Latency: grant in cycle t, response no earlier than t+1, entry visible on
//   o_out_valid no earlier than t+2 (registered FIFO, no bypass).
// Backpressure: i_out_ready low lets the FIFO fill. Requests are gated by a
//   credit rule (count + outstanding < DEPTH), so responses always find a free
//   slot and i_mem_rvalid is never stalled.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_redirect, i_redirect_pc    taken branch: flush and restart at target
//   o_mem_req, o_mem_addr        memory request (word aligned)
//   i_mem_gnt                    request accepted when o_mem_req && i_mem_gnt
//   i_mem_rvalid, i_mem_rdata    in-order response
//   o_out_valid, o_out_instr,
//   o_out_pc, i_out_ready        head of queue; pop when valid && ready

// ifetch_fifo: DEPTH-entry storage for {pc, instr} pairs with a flush.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none; the caller guarantees a push never meets a full FIFO.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic                     o_vld,
  output logic [WIDTH-1:0]         o_dat,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  // A flush wins over anything arriving in the same cycle.
  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && !i_flush && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity is carried by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  assign o_vld   = (r_count != '0);
  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_out_valid,
  output logic [31:0] o_out_instr,
  output logic [31:0] o_out_pc,
  input  logic        i_out_ready
);
  // Counters share one width; MAX_OUT <= DEPTH so outstanding/discard fit.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW-1:0] w_count;
  logic          w_credit_ok;
  logic          w_grant;
  logic          w_keep;
  logic          w_pop;
  logic          w_fifo_vld;
  logic [63:0]   w_fifo_dat;
  logic [31:0]   w_target;

  assign w_target = {i_redirect_pc[31:2], 2'b00};

  // A slot is reserved for every request in flight, so the sum must stay
  // below DEPTH before another request may go out.
  assign w_credit_ok = ({1'b0, w_count} + {1'b0, r_outstanding}) < DEPTH_C;

  assign o_mem_req  = !i_rst && !i_redirect &&
                      (r_outstanding < MAX_OUT_C) && w_credit_ok;
  assign o_mem_addr = r_fetch_pc;

  assign w_grant = o_mem_req && i_mem_gnt;

  // Responses belonging to requests issued before a redirect are dropped.
  // The one arriving in the redirect cycle itself is dropped here directly.
  assign w_keep = i_mem_rvalid && !i_redirect && (r_discard == '0);

  assign w_pop = w_fifo_vld && i_out_ready && !i_redirect;

  ifetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_redirect),
    .i_push     (w_keep),
    .i_push_dat ({r_resp_pc, i_mem_rdata}),
    .i_pop      (w_pop),
    .o_vld      (w_fifo_vld),
    .o_dat      (w_fifo_dat),
    .o_count    (w_count)
  );

  assign o_out_valid = w_fifo_vld;
  assign o_out_pc    = w_fifo_dat[63:32];
  assign o_out_instr = w_fifo_dat[31:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      // In-flight accounting is independent of redirects: stale requests
      // still occupy the memory pipe until their responses come back.
      case ({w_grant, i_mem_rvalid})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (i_redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        // Everything still in flight is stale. Because outstanding already
        // counts earlier discards, back-to-back redirects accumulate.
        r_discard  <= r_outstanding - CW'(i_mem_rvalid);
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_keep) begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (i_mem_rvalid && (r_discard != '0)) begin
          r_discard <= r_discard - 1'b1;
        end
      end
    end
  end
endmodule
